reg_file: RTL and testbench
===========================

# reg_file

Architectural register file at the receiving end of the writeback interface. Accepts one write per cycle (destination address, data, write enable) from the writeback stage, and serves two synchronous read ports to decode/operand fetch. Register 0 is hardwired to zero. A same-edge write-to-read bypass means a read never returns a stale value for a register being written on that edge.

## Interface
Parameters:
- ADDR_LEN, 5, register address width; number of registers is 2**ADDR_LEN.
- WORD_SIZE, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- w_en  input  1  write enable from writeback.
- dst_addr_i  input  ADDR_LEN  write destination address.
- data_i  input  WORD_SIZE  write data.
- rd_en  input  1  read enable; 0 = hold both read outputs (stall).
- rs1_addr  input  ADDR_LEN  read port 1 address.
- rs2_addr  input  ADDR_LEN  read port 2 address.
- rs1_data  output  WORD_SIZE  read port 1 data (registered).
- rs2_data  output  WORD_SIZE  read port 2 data (registered).

## Operation
- Storage: 2**ADDR_LEN words of WORD_SIZE bits. Entry 0 always reads 0.
- Write: on a rising clk edge with w_en=1 and dst_addr_i≠0, mem[dst_addr_i] <= data_i. Writes to address 0 are discarded without error.
- Read: on a rising clk edge with rd_en=1, rsN_data <= value of mem[rsN_addr] as it stands after that edge's write. The ports are independent and may use the same address.
- Bypass: if w_en=1, dst_addr_i=rsN_addr, dst_addr_i≠0 and rd_en=1 on the same edge, rsN_data <= data_i.
- rsN_addr=0 always yields 0, including when w_en=1 and dst_addr_i=0 with nonzero data_i.
- Stall: rd_en=0 holds rs1_data/rs2_data at their previous values. Writes proceed regardless of rd_en.
- Reset: rst=1 immediately clears all entries and both read outputs to 0, independent of clk. While rst=1, writes and reads are ignored. Operation resumes on the first rising edge after rst falls.
- No state machine. State consists of the register array plus the two output registers.

## Timing
- Reset values: rs1_data=0, rs2_data=0, every entry 0.
- Write latency: data is visible to a read sampled on the same edge through the bypass, and on all later edges from the array.
- Read latency: 1 cycle. Address sampled at edge N, data valid after edge N and held until the next edge with rd_en=1.
- Writeback protocol: the writeback stage raises w_en on the falling edge and drops it on the following rising edge. reg_file samples w_en=1 at that rising edge, giving exactly one write per writeback transaction. w_en, dst_addr_i and data_i must be stable across the rising edge.
- rst asserted mid-cycle: outputs drop to 0 asynchronously. A write sampled on an edge while rst=1 does not occur.
- Back-to-back writes to the same address: the last write wins. A read in the next cycle returns the second value.

## Test plan
- Reset: assert rst with prior nonzero contents → rs1_data=rs2_data=0 immediately. After release, reading addresses 1..31 returns 0.
- Basic write/read: write 0xDEADBEEF to r5, then read rs1_addr=5, rs2_addr=5 next cycle → both outputs 0xDEADBEEF one edge later.
- Zero register: write 0x12345678 to r0 → read r0 returns 0x00000000 on both the same-edge bypass and later reads.
- Bypass: r7=0x1111, then on one edge w_en=1, dst=7, data=0x2222 with rs1_addr=7 → rs1_data=0x2222 after that edge, not 0x1111.
- Stall: rs1_data=0xAAAA, set rd_en=0, change rs1_addr and write the new address → rs1_data stays 0xAAAA. With rd_en=1 on the next edge it updates to the written value.
- Async reset mid-write: rst pulse between edges while w_en=1, dst=3, data=0x55 → r3 reads 0 after release.

Source files
------------

// File: rtl/reg_file_if.sv
// reg_file_if
// Bundles the signals between the writeback/decode stages and the register file.
//   master : the pipeline side. It drives the write request (w_en, dst_addr_i,
//            data_i) and the read request (rd_en, rs1_addr, rs2_addr), and it
//            receives rs1_data and rs2_data.
//   slave  : the register file. It receives the requests and drives the read data.
// clk and rst are not part of this interface. They stay plain module ports.
interface reg_file_if #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32
);
    logic                 w_en;
    logic [ADDR_LEN-1:0]  dst_addr_i;
    logic [WORD_SIZE-1:0] data_i;
    logic                 rd_en;
    logic [ADDR_LEN-1:0]  rs1_addr;
    logic [ADDR_LEN-1:0]  rs2_addr;
    logic [WORD_SIZE-1:0] rs1_data;
    logic [WORD_SIZE-1:0] rs2_data;

    modport master (
        output w_en, dst_addr_i, data_i, rd_en, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  w_en, dst_addr_i, data_i, rd_en, rs1_addr, rs2_addr,
        output rs1_data, rs2_data
    );
endinterface

// File: rtl/reg_file.sv
// reg_file
// Architectural register file. It holds 2**ADDR_LEN words of WORD_SIZE bits.
// Register 0 always reads as zero.
//   - Write port: one write per cycle from writeback.
//   - Read ports: two synchronous read ports with registered outputs.
//   - Bypass: a write and a read of the same register on one edge return the
//     new data to the read.
//   - Stall: rd_en=0 holds both read outputs.
//   - Reset: rst is asynchronous and active high. It clears every entry and
//     both read outputs.
// Ports:
//   clk : system clock; all state changes on the rising edge.
//   rst : asynchronous active-high reset.
//   bus : reg_file_if.slave, which carries w_en, dst_addr_i, data_i, rd_en,
//         rs1_addr, rs2_addr, rs1_data and rs2_data.
module reg_file #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_LEN;

    // The entries are flops rather than block RAM because reset must clear
    // the whole array asynchronously. The entries are flattened into one
    // vector so that each generate block drives only its own slice.
    logic [NUM_REGS*WORD_SIZE-1:0] mem_flat;

    // A write to register 0 is never stored.
    logic wr_valid;
    assign wr_valid = bus.w_en && (bus.dst_addr_i != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                // Register 0 has no storage and always reads as zero.
                assign mem_flat[WORD_SIZE-1:0] = '0;
            end else begin : g_store
                logic [WORD_SIZE-1:0] entry_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        entry_reg <= '0;
                    end else if (wr_valid && (bus.dst_addr_i == ADDR_LEN'(gi))) begin
                        entry_reg <= bus.data_i;
                    end
                end

                assign mem_flat[gi*WORD_SIZE +: WORD_SIZE] = entry_reg;
            end
        end
    endgenerate

    // Each read port returns the array contents as they will stand after this
    // edge's write. If the port reads the register being written, the write
    // data is forwarded. wr_valid already excludes register 0, so address 0
    // always reads zero.
    logic [WORD_SIZE-1:0] rs1_next;
    logic [WORD_SIZE-1:0] rs2_next;

    always_comb begin
        rs1_next = mem_flat[int'(bus.rs1_addr)*WORD_SIZE +: WORD_SIZE];
        rs2_next = mem_flat[int'(bus.rs2_addr)*WORD_SIZE +: WORD_SIZE];
        if (wr_valid && (bus.dst_addr_i == bus.rs1_addr)) begin
            rs1_next = bus.data_i;
        end
        if (wr_valid && (bus.dst_addr_i == bus.rs2_addr)) begin
            rs2_next = bus.data_i;
        end
    end

    logic [WORD_SIZE-1:0] rs1_data_reg;
    logic [WORD_SIZE-1:0] rs2_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
        end else if (bus.rd_en) begin
            rs1_data_reg <= rs1_next;
            rs2_data_reg <= rs2_next;
        end
    end

    assign bus.rs1_data = rs1_data_reg;
    assign bus.rs2_data = rs2_data_reg;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
// Directed testbench for reg_file with hand-computed expected values.
// Inputs change on the falling edge, as the writeback stage drives them.
// Outputs are sampled 1 time unit after the rising edge.
module tb_reg_file;
    localparam int ADDR_LEN  = 5;
    localparam int WORD_SIZE = 32;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    reg_file_if #(.ADDR_LEN(ADDR_LEN), .WORD_SIZE(WORD_SIZE)) bus ();

    reg_file #(.ADDR_LEN(ADDR_LEN), .WORD_SIZE(WORD_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WORD_SIZE-1:0] observed,
                         input logic [WORD_SIZE-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, observed, expected);
    endtask

    // Runs one cycle. The task drives the inputs at the falling edge, lets the
    // rising edge sample them, and then drops w_en. That gives exactly one
    // write per writeback transaction.
    task automatic cycle(input logic we, input logic [ADDR_LEN-1:0] dst,
                         input logic [WORD_SIZE-1:0] data, input logic re,
                         input logic [ADDR_LEN-1:0] a1, input logic [ADDR_LEN-1:0] a2);
        @(negedge clk);
        bus.w_en       = we;
        bus.dst_addr_i = dst;
        bus.data_i     = data;
        bus.rd_en      = re;
        bus.rs1_addr   = a1;
        bus.rs2_addr   = a2;
        @(posedge clk);
        #1;
        bus.w_en = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst            = 1'b1;
        bus.w_en       = 1'b0;
        bus.dst_addr_i = '0;
        bus.data_i     = '0;
        bus.rd_en      = 1'b0;
        bus.rs1_addr   = '0;
        bus.rs2_addr   = '0;

        // Reset state
        #12;
        check("reset_rs1", bus.rs1_data, 32'h0);
        check("reset_rs2", bus.rs2_data, 32'h0);
        rst = 1'b0;

        // Basic write, then read with the outputs held during the write
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        check("write_stalled_rs1", bus.rs1_data, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        check("basic_rs1", bus.rs1_data, 32'hDEADBEEF);
        check("basic_rs2", bus.rs2_data, 32'hDEADBEEF);

        // Zero register: the same-edge read and the later read both return 0
        cycle(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0);
        check("zero_bypass_rs1", bus.rs1_data, 32'h0);
        check("zero_bypass_rs2", bus.rs2_data, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd5);
        check("zero_later_rs1", bus.rs1_data, 32'h0);
        check("zero_later_rs2", bus.rs2_data, 32'hDEADBEEF);

        // Bypass returns new data, not the stale value
        cycle(1'b1, 5'd7, 32'h00001111, 1'b1, 5'd5, 5'd5);
        check("pre_bypass_rs1", bus.rs1_data, 32'hDEADBEEF);
        cycle(1'b1, 5'd7, 32'h00002222, 1'b1, 5'd7, 5'd5);
        check("bypass_rs1", bus.rs1_data, 32'h00002222);
        check("bypass_other_rs2", bus.rs2_data, 32'hDEADBEEF);
        cycle(1'b1, 5'd9, 32'h0000CAFE, 1'b1, 5'd7, 5'd9);
        check("array_rs1_r7", bus.rs1_data, 32'h00002222);
        check("bypass_rs2", bus.rs2_data, 32'h0000CAFE);

        // Stall holds both outputs while the write still lands
        cycle(1'b1, 5'd10, 32'h0000AAAA, 1'b1, 5'd10, 5'd9);
        check("stall_setup_rs1", bus.rs1_data, 32'h0000AAAA);
        cycle(1'b1, 5'd11, 32'h0000BBBB, 1'b0, 5'd11, 5'd11);
        check("stall_hold_rs1", bus.rs1_data, 32'h0000AAAA);
        check("stall_hold_rs2", bus.rs2_data, 32'h0000CAFE);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd10);
        check("stall_release_rs1", bus.rs1_data, 32'h0000BBBB);
        check("stall_release_rs2", bus.rs2_data, 32'h0000AAAA);

        // Back-to-back writes: the last write wins
        cycle(1'b1, 5'd12, 32'h00000001, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 5'd12, 32'h00000002, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd10);
        check("b2b_rs1", bus.rs1_data, 32'h00000002);
        check("b2b_rs2", bus.rs2_data, 32'h0000AAAA);

        // Async reset mid-write: outputs clear at once, and the write is dropped
        @(negedge clk);
        bus.w_en       = 1'b1;
        bus.dst_addr_i = 5'd3;
        bus.data_i     = 32'h00000055;
        bus.rd_en      = 1'b1;
        bus.rs1_addr   = 5'd3;
        bus.rs2_addr   = 5'd3;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rs1", bus.rs1_data, 32'h0);
        check("async_rst_rs2", bus.rs2_data, 32'h0);
        @(posedge clk);
        #1;
        bus.w_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd5);
        check("rst_dropped_write_r3", bus.rs1_data, 32'h0);
        check("rst_cleared_r5", bus.rs2_data, 32'h0);

        // Every register reads 0 after reset
        for (int a = 1; a < 32; a++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'(32 - a));
            check($sformatf("post_rst_rs1_r%0d", a), bus.rs1_data, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
